// File: rtl/cnn_ctrl_pkg.sv
// Shared types and default sizing for the cv4 layer controller.
package cnn_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } cv4_ctrl_state_e;

   localparam int CV4_KERNEL_SIZE_DEF   = 4;
   localparam int CV4_IMG_COLS_DEF      = 5;
   localparam int CV4_OUT_CHANNELS_DEF  = 16;
   localparam int CV4_MEM_RD_LAT_DEF    = 1;
   localparam int CV4_DRAIN_TIMEOUT_DEF = 64;

   function automatic int cv4_out_cols(input int kernel_size, input int img_cols);
      return img_cols - kernel_size + 1;
   endfunction

endpackage

// File: rtl/cv4_rd_delay.sv
// Read-latency matching pipe: delays a memory read strobe by LAT cycles so it lines
// up with the returned data; flush clears everything in flight.
module cv4_rd_delay #(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic din,
   output logic dout,
   output logic pending
);

   logic [LAT-1:0] pipe_q;
   logic [LAT-1:0] pipe_d;
   logic [LAT-1:0] shift_in;

   if (LAT == 1) begin : g_one
      assign shift_in = din;
   end else begin : g_multi
      assign shift_in = {pipe_q[LAT-2:0], din};
   end

   always_comb begin
      pipe_d = flush ? '0 : shift_in;
   end

   always_ff @(posedge clk) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= pipe_d;
   end

   assign dout    = pipe_q[LAT-1];
   assign pending = |pipe_q;

endmodule

// File: rtl/cv4_layer_ctrl.sv
// Layer sequencer for one cv4 channel datapath: kernel load, activation stream, drain.
// Optional build macro CV4_CTRL_PERF_EN adds busy-cycle and stall-cycle counters.
//
//  state  | meaning
//  IDLE   | waiting for start; error flag holds its value
//  LOAD   | one kernel column read per cycle for the current output channel
//  STREAM | activation column reads, paused by stall_in
//  DRAIN  | waiting for all results of the channel and empty read pipes
//  DONE   | one-cycle done pulse
module cv4_layer_ctrl
   import cnn_ctrl_pkg::*;
#(
   parameter int KERNEL_SIZE   = CV4_KERNEL_SIZE_DEF,
   parameter int IMG_COLS      = CV4_IMG_COLS_DEF,
   parameter int OUT_CHANNELS  = CV4_OUT_CHANNELS_DEF,
   parameter int MEM_RD_LAT    = CV4_MEM_RD_LAT_DEF,
   parameter int DRAIN_TIMEOUT = CV4_DRAIN_TIMEOUT_DEF,
   localparam int OUT_COLS = cv4_out_cols(KERNEL_SIZE, IMG_COLS),
   localparam int KA_W     = $clog2(OUT_CHANNELS * KERNEL_SIZE),
   localparam int AA_W     = $clog2(IMG_COLS),
   localparam int OC_W     = $clog2(OUT_CHANNELS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stall_in,
   input  logic            dp_valid_out,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic            kern_rd_en,
   output logic [KA_W-1:0] kern_rd_addr,
   output logic            act_rd_en,
   output logic [AA_W-1:0] act_rd_addr,
   output logic            dp_kernel_load,
   output logic            dp_valid_in,
   output logic            out_valid,
   output logic [OC_W-1:0] out_oc,
   output logic [AA_W-1:0] out_col,
   output logic            out_last
`ifdef CV4_CTRL_PERF_EN
   ,
   output logic [31:0]     perf_cycles,
   output logic [31:0]     perf_stalls
`endif
);

   localparam int KW = $clog2(KERNEL_SIZE + 1);
   localparam int RW = AA_W + 1;
   localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

   cv4_ctrl_state_e state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [AA_W-1:0] col_q, col_d;
   logic [RW-1:0]   res_cnt_q, res_cnt_d;
   logic [OC_W-1:0] oc_q, oc_d;
   logic [DW-1:0]   drain_q, drain_d;
   logic            error_q, error_d;
   logic            abort;
   logic            start_acc;
   logic            kern_pend;
   logic            act_pend;
   logic            res_full;

   assign res_full = (res_cnt_q == RW'(OUT_COLS));

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      col_d     = col_q;
      res_cnt_d = res_cnt_q;
      oc_d      = oc_q;
      drain_d   = drain_q;
      error_d   = error_q;
      abort     = 1'b0;
      start_acc = 1'b0;
      case (state_q)
         IDLE: begin
            if (dp_valid_out) begin
               error_d = 1'b1;
            end else if (start) begin
               start_acc = 1'b1;
               error_d   = 1'b0;
               state_d   = LOAD;
               k_d       = '0;
               col_d     = '0;
               res_cnt_d = '0;
               oc_d      = '0;
               drain_d   = '0;
            end
         end
         LOAD: begin
            if (dp_valid_out) begin
               abort = 1'b1;
            end else if (k_q == KW'(KERNEL_SIZE - 1)) begin
               k_d     = '0;
               state_d = STREAM;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         STREAM: begin
            if (dp_valid_out) begin
               if (res_full) abort = 1'b1;
               else          res_cnt_d = res_cnt_q + 1'b1;
            end
            if (!stall_in) begin
               if (col_q == AA_W'(IMG_COLS - 1)) begin
                  col_d   = '0;
                  drain_d = '0;
                  state_d = DRAIN;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (dp_valid_out && res_full) begin
               abort = 1'b1;
            end else if (!dp_valid_out && res_full && !kern_pend && !act_pend) begin
               res_cnt_d = '0;
               drain_d   = '0;
               if (oc_q == OC_W'(OUT_CHANNELS - 1)) begin
                  state_d = DONE;
               end else begin
                  oc_d    = oc_q + 1'b1;
                  k_d     = '0;
                  state_d = LOAD;
               end
            end else if (drain_q == DW'(DRAIN_TIMEOUT - 1)) begin
               abort = 1'b1;
            end else begin
               drain_d = drain_q + 1'b1;
               if (dp_valid_out) res_cnt_d = res_cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (dp_valid_out) begin
               abort = 1'b1;
            end else begin
               oc_d    = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Any abort leaves the controller idle with clean tags and a sticky error.
      if (abort) begin
         state_d   = IDLE;
         error_d   = 1'b1;
         k_d       = '0;
         col_d     = '0;
         res_cnt_d = '0;
         oc_d      = '0;
         drain_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         k_q       <= '0;
         col_q     <= '0;
         res_cnt_q <= '0;
         oc_q      <= '0;
         drain_q   <= '0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         col_q     <= col_d;
         res_cnt_q <= res_cnt_d;
         oc_q      <= oc_d;
         drain_q   <= drain_d;
         error_q   <= error_d;
      end
   end

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE) && !dp_valid_out;
   assign error        = error_q;
   assign kern_rd_en   = (state_q == LOAD);
   assign kern_rd_addr = KA_W'(int'(oc_q) * KERNEL_SIZE + int'(k_q));
   assign act_rd_en    = (state_q == STREAM) && !stall_in;
   assign act_rd_addr  = col_q;
   assign out_valid    = dp_valid_out && ((state_q == STREAM) || (state_q == DRAIN));
   assign out_oc       = oc_q;
   assign out_col      = res_cnt_q[AA_W-1:0];
   assign out_last     = out_valid && (oc_q == OC_W'(OUT_CHANNELS - 1))
                         && (res_cnt_q == RW'(OUT_COLS - 1));

   cv4_rd_delay #(.LAT(MEM_RD_LAT)) u_kern_dly (
      .clk     (clk),
      .rst     (rst),
      .flush   (abort),
      .din     (kern_rd_en),
      .dout    (dp_kernel_load),
      .pending (kern_pend)
   );

   cv4_rd_delay #(.LAT(MEM_RD_LAT)) u_act_dly (
      .clk     (clk),
      .rst     (rst),
      .flush   (abort),
      .din     (act_rd_en),
      .dout    (dp_valid_in),
      .pending (act_pend)
   );

`ifdef CV4_CTRL_PERF_EN
   logic [31:0] perf_cycles_q, perf_cycles_d;
   logic [31:0] perf_stalls_q, perf_stalls_d;

   always_comb begin
      perf_cycles_d = perf_cycles_q;
      perf_stalls_d = perf_stalls_q;
      if (start_acc) begin
         perf_cycles_d = '0;
         perf_stalls_d = '0;
      end else begin
         if (busy && (perf_cycles_q != '1))
            perf_cycles_d = perf_cycles_q + 1'b1;
         if ((state_q == STREAM) && stall_in && (perf_stalls_q != '1))
            perf_stalls_d = perf_stalls_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         perf_cycles_q <= perf_cycles_d;
         perf_stalls_q <= perf_stalls_d;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_cv4_layer_ctrl.sv
// Directed bench for cv4_layer_ctrl with a latency-8 datapath model; perf counters
// are checked too when CV4_CTRL_PERF_EN is defined.
module tb_cv4_layer_ctrl;

   localparam int KS    = 4;
   localparam int IMG   = 5;
   localparam int NOC   = 2;
   localparam int LAT   = 1;
   localparam int TO    = 64;
   localparam int OCOLS = IMG - KS + 1;
   localparam int KA_W  = $clog2(NOC * KS);
   localparam int AA_W  = $clog2(IMG);
   localparam int OC_W  = $clog2(NOC);

   logic            clk;
   logic            rst;
   logic            start;
   logic            stall_in;
   logic            dp_valid_out;
   logic            busy;
   logic            done;
   logic            error;
   logic            kern_rd_en;
   logic [KA_W-1:0] kern_rd_addr;
   logic            act_rd_en;
   logic [AA_W-1:0] act_rd_addr;
   logic            dp_kernel_load;
   logic            dp_valid_in;
   logic            out_valid;
   logic [OC_W-1:0] out_oc;
   logic [AA_W-1:0] out_col;
   logic            out_last;
`ifdef CV4_CTRL_PERF_EN
   logic [31:0]     perf_cycles;
   logic [31:0]     perf_stalls;
`endif

   cv4_layer_ctrl #(
      .KERNEL_SIZE   (KS),
      .IMG_COLS      (IMG),
      .OUT_CHANNELS  (NOC),
      .MEM_RD_LAT    (LAT),
      .DRAIN_TIMEOUT (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .stall_in       (stall_in),
      .dp_valid_out   (dp_valid_out),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .kern_rd_en     (kern_rd_en),
      .kern_rd_addr   (kern_rd_addr),
      .act_rd_en      (act_rd_en),
      .act_rd_addr    (act_rd_addr),
      .dp_kernel_load (dp_kernel_load),
      .dp_valid_in    (dp_valid_in),
      .out_valid      (out_valid),
      .out_oc         (out_oc),
      .out_col        (out_col),
      .out_last       (out_last)
`ifdef CV4_CTRL_PERF_EN
      ,
      .perf_cycles    (perf_cycles),
      .perf_stalls    (perf_stalls)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Datapath model: a result for column j leaves 8 cycles after activation beat j+KS-1.
   logic       force_vo;
   logic       drop_en;
   logic [7:0] sr;
   int         beat;
   logic       gen;

   assign gen = dp_valid_in && (beat >= KS - 1) && !(drop_en && (beat == KS - 1));
   assign dp_valid_out = sr[7] | force_vo;

   always @(posedge clk) begin
      if (rst) begin
         sr   <= '0;
         beat <= 0;
      end else begin
         sr <= {sr[6:0], gen};
         if (dp_kernel_load)   beat <= 0;
         else if (dp_valid_in) beat <= beat + 1;
      end
   end

   // Monitor: owns all per-run counters, checks address and tag sequences live.
   logic mon_en;
   int   run_id = 0;
   int   seen_id = 0;
   int   n_kern, n_act, n_kl, n_vi, n_res, n_done, n_busy;
   int   cyc, last_act_cyc, err_cyc, err_busy;
   logic prev_err;

   always @(negedge clk) begin
      if (run_id != seen_id) begin
         seen_id = run_id;
         n_kern = 0; n_act = 0; n_kl = 0; n_vi = 0; n_res = 0;
         n_done = 0; n_busy = 0; cyc = 0; last_act_cyc = -1;
         err_cyc = -1; err_busy = -1; prev_err = error;
      end else if (mon_en) begin
         if (kern_rd_en) begin
            chk("kern_addr", int'(kern_rd_addr), n_kern);
            n_kern++;
         end
         if (act_rd_en) begin
            chk("act_addr", int'(act_rd_addr), n_act % IMG);
            n_act++;
            last_act_cyc = cyc;
         end
         if (dp_kernel_load) n_kl++;
         if (dp_valid_in)    n_vi++;
         if (out_valid) begin
            chk("res_oc", int'(out_oc), n_res / OCOLS);
            chk("res_col", int'(out_col), n_res % OCOLS);
            chk("res_last", int'(out_last), (n_res == NOC * OCOLS - 1) ? 1 : 0);
            n_res++;
         end
         if (done) n_done++;
         if (busy) n_busy++;
         if (error && !prev_err && (err_cyc < 0)) begin
            err_cyc  = cyc;
            err_busy = int'(busy);
         end
         prev_err = error;
         cyc++;
      end
   end

   function automatic int all_outs();
      return int'({busy, done, error, kern_rd_en, kern_rd_addr, act_rd_en, act_rd_addr,
                   dp_kernel_load, dp_valid_in, out_valid, out_oc, out_col, out_last});
   endfunction

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_layer(input bit do_stall, input bit do_drop);
      bit ended;
      bit stalled;
      drop_en = do_drop;
      run_id++;
      @(negedge clk);
      mon_en = 1'b1;
      pulse_start();
      ended   = 1'b0;
      stalled = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!busy) begin
            ended = 1'b1;
            break;
         end
         if (do_stall && !stalled && act_rd_en && (act_rd_addr == 3'd2)) begin
            stalled = 1'b1;
            @(posedge clk); #1 stall_in = 1'b1;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               chk("stall_act_en", int'(act_rd_en), 0);
               chk("stall_act_addr", int'(act_rd_addr), 3);
               @(posedge clk);
            end
            #1 stall_in = 1'b0;
         end
      end
      chk("run_terminates", int'(ended), 1);
      if (do_stall) chk("stall_seen", int'(stalled), 1);
      repeat (2) @(negedge clk);
      mon_en  = 1'b0;
      drop_en = 1'b0;
   endtask

   typedef struct {
      int pre;      // 0 none, 1 result pulse in IDLE, 2 reset mid-STREAM
      bit stall;
      bit drop;
      int e_res;
      int e_kern;
      int e_act;
      int e_done;
      int e_err;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{pre: 0, stall: 0, drop: 0, e_res: 4, e_kern: 8, e_act: 10, e_done: 1, e_err: 0};
      vecs[1] = '{pre: 0, stall: 1, drop: 0, e_res: 4, e_kern: 8, e_act: 10, e_done: 1, e_err: 0};
      vecs[2] = '{pre: 1, stall: 0, drop: 0, e_res: 4, e_kern: 8, e_act: 10, e_done: 1, e_err: 0};
      vecs[3] = '{pre: 0, stall: 0, drop: 1, e_res: 1, e_kern: 4, e_act: 5,  e_done: 0, e_err: 1};
      vecs[4] = '{pre: 2, stall: 0, drop: 0, e_res: 4, e_kern: 8, e_act: 10, e_done: 1, e_err: 0};

      rst = 1'b1; start = 1'b0; stall_in = 1'b0; force_vo = 1'b0;
      drop_en = 1'b0; mon_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("reset_outputs", all_outs(), 0);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("idle_outputs", all_outs(), 0);

      for (int v = 0; v < 5; v++) begin
         if (vecs[v].pre == 1) begin
            @(posedge clk); #1 force_vo = 1'b1;
            @(negedge clk);
            chk("idle_pulse_out_valid", int'(out_valid), 0);
            @(posedge clk); #1 force_vo = 1'b0;
            chk("idle_pulse_error", int'(error), 1);
            chk("idle_pulse_busy", int'(busy), 0);
            @(posedge clk); #1
            chk("error_sticky", int'(error), 1);
         end else if (vecs[v].pre == 2) begin
            bit seen;
            mon_en = 1'b0;
            pulse_start();
            seen = 1'b0;
            for (int c = 0; c < 100; c++) begin
               @(negedge clk);
               if (act_rd_en) begin
                  seen = 1'b1;
                  break;
               end
            end
            chk("reach_stream", int'(seen), 1);
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1
            chk("midrun_reset_outputs", all_outs(), 0);
            start = 1'b1;
            @(posedge clk); #1
            chk("rst_beats_start", int'(busy), 0);
            rst = 1'b0; start = 1'b0;
            @(posedge clk); #1
            chk("after_rst_idle", all_outs(), 0);
         end

         run_layer(vecs[v].stall, vecs[v].drop);

         chk("results", n_res, vecs[v].e_res);
         chk("kern_beats", n_kern, vecs[v].e_kern);
         chk("kernel_load_beats", n_kl, vecs[v].e_kern);
         chk("act_beats", n_act, vecs[v].e_act);
         chk("valid_in_beats", n_vi, vecs[v].e_act);
         chk("done_cycles", n_done, vecs[v].e_done);
         chk("error_end", int'(error), vecs[v].e_err);
         chk("busy_end", int'(busy), 0);
         if (vecs[v].e_err != 0) begin
            chk("drain_window", err_cyc - last_act_cyc, TO + 1);
            chk("busy_at_error", err_busy, 0);
         end
`ifdef CV4_CTRL_PERF_EN
         chk("perf_cycles", int'(perf_cycles), n_busy);
         chk("perf_stalls", int'(perf_stalls), vecs[v].stall ? 3 : 0);
`endif
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
